// File: rtl/core_pkg.sv
// Shared definitions for the EX/MEM pipeline register: state encoding, default
// shadow depth, the control bundle carried to Memory and a saturating-increment helper.
package core_pkg;

  typedef enum logic {
    MOD_RUN    = 1'b0,
    MOD_SHADOW = 1'b1
  } mod_state_e;

  localparam int SHADOW_DEPTH_DEF = 2;
  localparam int REG_ADDR_W       = 5;

  typedef struct packed {
    logic                  valid;
    logic                  mem_wEn;
    logic                  reg_wEn;
    logic [REG_ADDR_W-1:0] writeback_Reg;
  } ex_mem_ctrl_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_shadow_ctrl.sv
// Owns the RUN/SHADOW state, the shadow counter and the one-cycle Fetch redirect
// for a taken branch leaving Execute.
module branch_shadow_ctrl
  import core_pkg::*;
#(
  parameter int PC_WIDTH     = 16,
  parameter int SHADOW_DEPTH = SHADOW_DEPTH_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                dump,
  input  logic                stall,
  input  logic                ex_valid,
  input  logic                ex_taken,
  input  logic [PC_WIDTH-1:0] ex_target,
  output logic                shadow,
  output logic                redirect_valid,
  output logic [PC_WIDTH-1:0] redirect_pc
);

  localparam logic [2:0] DEPTH3 = 3'(SHADOW_DEPTH);

  if (SHADOW_DEPTH < 1 || SHADOW_DEPTH > 7) begin : g_depth_chk
    $error("SHADOW_DEPTH must be in 1..7");
  end

  mod_state_e state;
  logic [2:0] cnt;

  assign shadow = (state == MOD_SHADOW);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= MOD_RUN;
      cnt            <= 3'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else if (dump) begin
      state          <= MOD_RUN;
      cnt            <= 3'd0;
      redirect_valid <= 1'b0;
    end else if (stall) begin
      // Holding must never replay a redirect Fetch has already taken.
      redirect_valid <= 1'b0;
    end else if (state == MOD_RUN) begin
      if (ex_valid && ex_taken) begin
        redirect_pc    <= ex_target;
        redirect_valid <= 1'b1;
        cnt            <= DEPTH3;
        state          <= MOD_SHADOW;
      end else begin
        redirect_valid <= 1'b0;
      end
    end else begin
      redirect_valid <= 1'b0;
      cnt            <= cnt - 3'd1;
      if (cnt == 3'd1) state <= MOD_RUN;
    end
  end

endmodule

// File: rtl/execute_memory_moderator.sv
// EX/MEM pipeline register with branch redirect/squash and the EX/MEM forwarding source.
// Define EX_MEM_STATS_EN to build the retired/squash/stall statistics counters.
module execute_memory_moderator
  import core_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int PC_WIDTH       = 16,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int SHADOW_DEPTH   = SHADOW_DEPTH_DEF
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [DATA_WIDTH-1:0]     ALU_Result_Out,
  input  logic [DATA_WIDTH-1:0]     store_Data_Out,
  input  logic                      mem_wEn_Out_Execute,
  input  logic                      reg_wEn_Out_Execute,
  input  logic [REG_ADDR_WIDTH-1:0] writeback_Reg_Out_Execute,
  input  logic [PC_WIDTH-1:0]       PC_Out_Execute,
  input  logic                      valid_Out_Execute,
  input  logic                      next_PC_select_Out,
  input  logic [PC_WIDTH-1:0]       target_PC_Out,
  input  logic                      DUMP,
  input  logic                      STALL,
  output logic [DATA_WIDTH-1:0]     ALU_Result_In,
  output logic [DATA_WIDTH-1:0]     store_Data_In,
  output logic                      mem_wEn_in_Memory,
  output logic                      reg_wEn_in_Memory,
  output logic [REG_ADDR_WIDTH-1:0] writeback_Reg_In_Memory,
  output logic [PC_WIDTH-1:0]       PC_In_Memory,
  output logic                      valid_In_Memory,
  output logic                      redirect_Valid,
  output logic [PC_WIDTH-1:0]       redirect_PC,
  output logic                      fwd_Valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_Reg,
  output logic [DATA_WIDTH-1:0]     fwd_Data,
  output logic [31:0]               retired_Count,
  output logic [31:0]               squash_Count,
  output logic [31:0]               stall_Count
);

  if (REG_ADDR_WIDTH != REG_ADDR_W) begin : g_rw_chk
    $error("REG_ADDR_WIDTH must match core_pkg::REG_ADDR_W");
  end

  logic shadow;
  logic capture;
  logic load_valid;

  ex_mem_ctrl_t          ctrl_q;
  logic [DATA_WIDTH-1:0] alu_q, sd_q;
  logic [PC_WIDTH-1:0]   pc_q;

  branch_shadow_ctrl #(
    .PC_WIDTH    (PC_WIDTH),
    .SHADOW_DEPTH(SHADOW_DEPTH)
  ) u_shadow (
    .clock         (clock),
    .reset_n       (reset_n),
    .dump          (DUMP),
    .stall         (STALL),
    .ex_valid      (valid_Out_Execute),
    .ex_taken      (next_PC_select_Out),
    .ex_target     (target_PC_Out),
    .shadow        (shadow),
    .redirect_valid(redirect_Valid),
    .redirect_pc   (redirect_PC)
  );

  assign capture    = !DUMP && !STALL;
  // Wrong-path instructions inside the shadow window are loaded as bubbles.
  assign load_valid = valid_Out_Execute && !shadow;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= '0;
      alu_q  <= '0;
      sd_q   <= '0;
      pc_q   <= '0;
    end else if (DUMP) begin
      ctrl_q.valid   <= 1'b0;
      ctrl_q.mem_wEn <= 1'b0;
      ctrl_q.reg_wEn <= 1'b0;
    end else if (capture) begin
      ctrl_q.valid         <= load_valid;
      ctrl_q.mem_wEn       <= mem_wEn_Out_Execute && load_valid;
      ctrl_q.reg_wEn       <= reg_wEn_Out_Execute && load_valid;
      ctrl_q.writeback_Reg <= writeback_Reg_Out_Execute;
      alu_q                <= ALU_Result_Out;
      sd_q                 <= store_Data_Out;
      pc_q                 <= PC_Out_Execute;
    end
  end

  assign ALU_Result_In           = alu_q;
  assign store_Data_In           = sd_q;
  assign mem_wEn_in_Memory       = ctrl_q.mem_wEn;
  assign reg_wEn_in_Memory       = ctrl_q.reg_wEn;
  assign writeback_Reg_In_Memory = ctrl_q.writeback_Reg;
  assign PC_In_Memory            = pc_q;
  assign valid_In_Memory         = ctrl_q.valid;

  assign fwd_Valid = ctrl_q.valid && ctrl_q.reg_wEn && (ctrl_q.writeback_Reg != '0);
  assign fwd_Reg   = ctrl_q.writeback_Reg;
  assign fwd_Data  = alu_q;

`ifdef EX_MEM_STATS_EN
  logic [31:0] ret_q, sq_q, st_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ret_q <= '0;
      sq_q  <= '0;
      st_q  <= '0;
    end else if (DUMP) begin
      if (valid_Out_Execute) sq_q <= sat_inc(sq_q);
    end else if (STALL) begin
      st_q <= sat_inc(st_q);
    end else if (valid_Out_Execute) begin
      if (shadow) sq_q  <= sat_inc(sq_q);
      else        ret_q <= sat_inc(ret_q);
    end
  end

  assign retired_Count = ret_q;
  assign squash_Count  = sq_q;
  assign stall_Count   = st_q;
`else
  assign retired_Count = 32'd0;
  assign squash_Count  = 32'd0;
  assign stall_Count   = 32'd0;
`endif

endmodule

// File: tb/tb_execute_memory_moderator.sv
// Directed bench for execute_memory_moderator: a behavioural model of the
// pipeline slot plus literal spot checks on the headline scenarios.
module tb_execute_memory_moderator;

  localparam int DW = 32, PW = 16, RW = 5, DEPTH = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] ALU_Result_Out = '0, store_Data_Out = '0;
  logic          mem_wEn_Out_Execute = 0, reg_wEn_Out_Execute = 0;
  logic [RW-1:0] writeback_Reg_Out_Execute = '0;
  logic [PW-1:0] PC_Out_Execute = '0, target_PC_Out = '0;
  logic          valid_Out_Execute = 0, next_PC_select_Out = 0, DUMP = 0, STALL = 0;

  logic [DW-1:0] ALU_Result_In, store_Data_In, fwd_Data;
  logic          mem_wEn_in_Memory, reg_wEn_in_Memory, valid_In_Memory, redirect_Valid, fwd_Valid;
  logic [RW-1:0] writeback_Reg_In_Memory, fwd_Reg;
  logic [PW-1:0] PC_In_Memory, redirect_PC;
  logic [31:0]   retired_Count, squash_Count, stall_Count;

  execute_memory_moderator #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .REG_ADDR_WIDTH(RW),
                             .SHADOW_DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .ALU_Result_Out(ALU_Result_Out), .store_Data_Out(store_Data_Out),
    .mem_wEn_Out_Execute(mem_wEn_Out_Execute), .reg_wEn_Out_Execute(reg_wEn_Out_Execute),
    .writeback_Reg_Out_Execute(writeback_Reg_Out_Execute), .PC_Out_Execute(PC_Out_Execute),
    .valid_Out_Execute(valid_Out_Execute), .next_PC_select_Out(next_PC_select_Out),
    .target_PC_Out(target_PC_Out), .DUMP(DUMP), .STALL(STALL),
    .ALU_Result_In(ALU_Result_In), .store_Data_In(store_Data_In),
    .mem_wEn_in_Memory(mem_wEn_in_Memory), .reg_wEn_in_Memory(reg_wEn_in_Memory),
    .writeback_Reg_In_Memory(writeback_Reg_In_Memory), .PC_In_Memory(PC_In_Memory),
    .valid_In_Memory(valid_In_Memory), .redirect_Valid(redirect_Valid),
    .redirect_PC(redirect_PC), .fwd_Valid(fwd_Valid), .fwd_Reg(fwd_Reg), .fwd_Data(fwd_Data),
    .retired_Count(retired_Count), .squash_Count(squash_Count), .stall_Count(stall_Count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the slot contents and how many younger instructions remain to be squashed.
  logic [DW-1:0] m_alu = '0, m_sd = '0;
  logic [RW-1:0] m_rd = '0;
  logic [PW-1:0] m_pc = '0, m_rpc = '0;
  logic          m_valid = 0, m_mw = 0, m_rw = 0, m_rv = 0;
  int            left = 0;
  longint        m_ret = 0, m_sq = 0, m_st = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_alu = '0; m_sd = '0; m_rd = '0; m_pc = '0; m_rpc = '0;
      m_valid = 0; m_mw = 0; m_rw = 0; m_rv = 0; left = 0;
      m_ret = 0; m_sq = 0; m_st = 0;
    end else if (DUMP) begin
      m_valid = 0; m_mw = 0; m_rw = 0; m_rv = 0; left = 0;
      if (valid_Out_Execute) m_sq++;
    end else if (STALL) begin
      m_rv = 0; m_st++;
    end else begin
      m_alu = ALU_Result_Out; m_sd = store_Data_Out; m_rd = writeback_Reg_Out_Execute;
      m_pc = PC_Out_Execute; m_rv = 0;
      if (left > 0) begin
        left--;
        m_valid = 0; m_mw = 0; m_rw = 0;
        if (valid_Out_Execute) m_sq++;
      end else begin
        m_valid = valid_Out_Execute;
        m_mw = mem_wEn_Out_Execute & valid_Out_Execute;
        m_rw = reg_wEn_Out_Execute & valid_Out_Execute;
        if (valid_Out_Execute) m_ret++;
        if (valid_Out_Execute && next_PC_select_Out) begin
          m_rv = 1; m_rpc = target_PC_Out; left = DEPTH;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      chk("alu",    64'(ALU_Result_In), 64'(m_alu));
      chk("sdata",  64'(store_Data_In), 64'(m_sd));
      chk("mem_wen", 64'(mem_wEn_in_Memory), 64'(m_mw));
      chk("reg_wen", 64'(reg_wEn_in_Memory), 64'(m_rw));
      chk("rd",     64'(writeback_Reg_In_Memory), 64'(m_rd));
      chk("pc",     64'(PC_In_Memory), 64'(m_pc));
      chk("valid",  64'(valid_In_Memory), 64'(m_valid));
      chk("rvalid", 64'(redirect_Valid), 64'(m_rv));
      chk("rpc",    64'(redirect_PC), 64'(m_rpc));
      chk("fwd_valid", 64'(fwd_Valid), 64'(m_valid && m_rw && (m_rd != 0)));
      chk("fwd_reg",  64'(fwd_Reg), 64'(m_rd));
      chk("fwd_data", 64'(fwd_Data), 64'(m_alu));
`ifdef EX_MEM_STATS_EN
      chk("retired", 64'(retired_Count), 64'(m_ret));
      chk("squash",  64'(squash_Count), 64'(m_sq));
      chk("stalls",  64'(stall_Count), 64'(m_st));
`else
      chk("retired", 64'(retired_Count), 64'd0);
      chk("squash",  64'(squash_Count), 64'd0);
      chk("stalls",  64'(stall_Count), 64'd0);
`endif
    end
  end

  task automatic tick();
    @(negedge clock); #1;
  endtask

  task automatic drv(input logic v, input logic [DW-1:0] alu, input logic mw, input logic rw,
                     input logic [RW-1:0] rd, input logic [PW-1:0] pc,
                     input logic tk, input logic [PW-1:0] tgt);
    valid_Out_Execute = v; ALU_Result_Out = alu; store_Data_Out = ~alu;
    mem_wEn_Out_Execute = mw; reg_wEn_Out_Execute = rw; writeback_Reg_Out_Execute = rd;
    PC_Out_Execute = pc; next_PC_select_Out = tk; target_PC_Out = tgt;
  endtask

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      drv(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 5'($urandom), 16'($urandom),
          1'($urandom), 16'($urandom));
      DUMP = 1'($urandom); STALL = 1'($urandom);
      @(posedge clock);
    end
    @(negedge clock);
    drv(0, 0, 0, 0, 0, 0, 0, 0); DUMP = 0; STALL = 0;
    reset_n = 1;
    #1;
    chk("lit_reset_valid", 64'(valid_In_Memory), 64'd0);
    chk("lit_reset_alu",   64'(ALU_Result_In), 64'd0);
    chk("lit_reset_fwd",   64'(fwd_Valid), 64'd0);
    chk("lit_reset_rv",    64'(redirect_Valid), 64'd0);

    // Straight-line
    drv(1, 32'h0000_1234, 0, 1, 5, 16'h0010, 0, 0); tick();
    chk("lit_alu", 64'(ALU_Result_In), 64'h1234);
    chk("lit_fwd_valid", 64'(fwd_Valid), 64'd1);
    chk("lit_fwd_reg", 64'(fwd_Reg), 64'd5);
    drv(1, 32'h0000_5678, 0, 1, 0, 16'h0014, 0, 0); tick();
    chk("lit_fwd_x0", 64'(fwd_Valid), 64'd0);

    // Taken branch then two shadow slots
    drv(1, 32'hB0, 1, 0, 0, 16'h0040, 1, 16'h0080); tick();
    chk("lit_br_rv", 64'(redirect_Valid), 64'd1);
    chk("lit_br_rpc", 64'(redirect_PC), 64'h0080);
    chk("lit_br_valid", 64'(valid_In_Memory), 64'd1);
    drv(1, 32'hA1, 1, 1, 7, 16'h0044, 0, 0); tick();
    chk("lit_sh1_valid", 64'(valid_In_Memory), 64'd0);
    chk("lit_sh1_mw", 64'(mem_wEn_in_Memory), 64'd0);
    chk("lit_sh1_rv", 64'(redirect_Valid), 64'd0);
    drv(1, 32'hA2, 1, 1, 8, 16'h0048, 0, 0); tick();
    chk("lit_sh2_valid", 64'(valid_In_Memory), 64'd0);
    drv(1, 32'hA3, 1, 1, 9, 16'h0080, 0, 0); tick();
    chk("lit_after_valid", 64'(valid_In_Memory), 64'd1);

    // Stall inside shadow
    drv(1, 32'hC0, 0, 0, 0, 16'h0100, 1, 16'h0200); tick();
    chk("lit_st_rv", 64'(redirect_Valid), 64'd1);
    STALL = 1;
    drv(1, 32'hC1, 1, 1, 3, 16'h0104, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lit_st_hold_rv", 64'(redirect_Valid), 64'd0);
      chk("lit_st_hold_valid", 64'(valid_In_Memory), 64'd1);
    end
`ifdef EX_MEM_STATS_EN
    chk("lit_stall_count", 64'(stall_Count), 64'd3);
`endif
    STALL = 0; tick();
    chk("lit_st_sq1", 64'(valid_In_Memory), 64'd0);
    drv(1, 32'hC2, 1, 1, 4, 16'h0108, 0, 0); tick();
    chk("lit_st_sq2", 64'(valid_In_Memory), 64'd0);
    drv(1, 32'hC3, 1, 1, 4, 16'h0200, 0, 0); tick();
    chk("lit_st_resume", 64'(valid_In_Memory), 64'd1);

    // DUMP with STALL right after a branch
    drv(1, 32'hD0, 0, 0, 0, 16'h0300, 1, 16'h0400); tick();
    DUMP = 1; STALL = 1;
    drv(1, 32'hD1, 1, 1, 6, 16'h0304, 0, 0); tick();
    chk("lit_dump_valid", 64'(valid_In_Memory), 64'd0);
    chk("lit_dump_rv", 64'(redirect_Valid), 64'd0);
    DUMP = 0; STALL = 0;
    drv(1, 32'hD2, 0, 1, 6, 16'h0400, 0, 0); tick();
    chk("lit_dump_next", 64'(valid_In_Memory), 64'd1);

    // Nested taken branch in the shadow
    drv(1, 32'hE0, 0, 0, 0, 16'h0500, 1, 16'h0100); tick();
    drv(1, 32'hE1, 0, 0, 0, 16'h0504, 1, 16'h0200); tick();
    chk("lit_nest_rv", 64'(redirect_Valid), 64'd0);
    chk("lit_nest_rpc", 64'(redirect_PC), 64'h0100);
    chk("lit_nest_valid", 64'(valid_In_Memory), 64'd0);
    drv(1, 32'hE2, 0, 1, 2, 16'h0508, 0, 0); tick();
    chk("lit_nest_sq2", 64'(valid_In_Memory), 64'd0);
    drv(1, 32'hE3, 0, 1, 2, 16'h0100, 0, 0); tick();
    chk("lit_nest_resume", 64'(valid_In_Memory), 64'd1);

    // Reset in the middle of a shadow window
    drv(1, 32'hF0, 0, 0, 0, 16'h0600, 1, 16'h0700); tick();
    reset_n = 0; #2; reset_n = 1;
    drv(1, 32'hF1, 0, 1, 1, 16'h0604, 0, 0); tick();
    chk("lit_rst_shadow", 64'(valid_In_Memory), 64'd1);

    drv(0, 0, 0, 0, 0, 0, 0, 0); tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute_memory_moderator.md
Name: execute_memory_moderator

Overview:
- EX/MEM pipeline register for the 5-stage RISC-V core; captures Execute results and carries control bits to the Memory stage.
- Resolves taken branches leaving Execute: issues a one-cycle redirect to Fetch and squashes younger wrong-path instructions through a shadow window.
- Provides the EX/MEM forwarding source to the Execute operand muxes.

Parameters:
- DATA_WIDTH, 32, ALU result and store-data width
- PC_WIDTH, 16, program-counter width
- REG_ADDR_WIDTH, 5, register-file address width
- SHADOW_DEPTH, 2, number of younger instructions squashed after a taken branch (range 1..7)

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- ALU_Result_Out  in  DATA_WIDTH  Execute ALU result
- store_Data_Out  in  DATA_WIDTH  rs2 value for stores
- mem_wEn_Out_Execute  in  1  store enable
- reg_wEn_Out_Execute  in  1  register writeback enable
- writeback_Reg_Out_Execute  in  REG_ADDR_WIDTH  destination register
- PC_Out_Execute  in  PC_WIDTH  instruction PC
- valid_Out_Execute  in  1  Execute holds a real instruction
- next_PC_select_Out  in  1  branch/jump taken
- target_PC_Out  in  PC_WIDTH  taken target
- DUMP  in  1  flush request
- STALL  in  1  hold request
- ALU_Result_In  out  DATA_WIDTH  registered ALU result
- store_Data_In  out  DATA_WIDTH  registered store data
- mem_wEn_in_Memory  out  1  gated store enable
- reg_wEn_in_Memory  out  1  gated writeback enable
- writeback_Reg_In_Memory  out  REG_ADDR_WIDTH  registered destination
- PC_In_Memory  out  PC_WIDTH  registered PC
- valid_In_Memory  out  1  Memory slot holds a real instruction
- redirect_Valid  out  1  one-cycle Fetch redirect
- redirect_PC  out  PC_WIDTH  redirect target
- fwd_Valid  out  1  forwarding source usable
- fwd_Reg  out  REG_ADDR_WIDTH  forwarding destination
- fwd_Data  out  DATA_WIDTH  forwarding value
- retired_Count, squash_Count, stall_Count  out  32 each  statistics counters

Behaviour:
- Reset: an asynchronous low on reset_n clears every registered output to 0 and sets state to RUN with shadow counter 0. A reset mid-shadow abandons the shadow window.
- Edge priority, per rising edge: DUMP > STALL > capture.
- DUMP: the slot becomes a bubble (valid, wEn bits and redirect_Valid = 0; data fields hold their old values). State goes to RUN and the counter is cleared. No redirect is issued. DUMP asserted together with STALL behaves as DUMP.
- STALL (without DUMP): all registers hold, except that redirect_Valid is forced to 0 so a redirect is never reissued. The shadow counter holds.
- Capture in RUN: every field is loaded from its Execute input. mem_wEn and reg_wEn are ANDed with valid_Out_Execute.
  - If valid_Out_Execute=1 and next_PC_select_Out=1: redirect_PC is set to target_PC_Out, redirect_Valid is set to 1, the counter is loaded with SHADOW_DEPTH, and state goes to SHADOW.
  - Otherwise redirect_Valid is set to 0.
- Capture in SHADOW: the incoming instruction is loaded as a bubble (valid, wEn bits = 0). The counter decrements, and the state returns to RUN when it reaches 0. A taken branch arriving in SHADOW is squashed and never redirects. redirect_Valid = 0.
- Latency: one cycle, Execute to Memory. redirect_Valid is high in the same cycle the branch is visible at valid_In_Memory, for exactly one cycle.
- Forwarding (combinational from the registers):
  - fwd_Valid = valid_In_Memory & reg_wEn_in_Memory & (writeback_Reg_In_Memory != 0)
  - fwd_Reg = writeback_Reg_In_Memory
  - fwd_Data = ALU_Result_In
- Widths: all fields pass through unmodified; no arithmetic on data paths. The counter is 3 bits.

Optional Feature:
- Macro: EX_MEM_STATS_EN.
- Defined: three 32-bit counters, each saturating at 0xFFFFFFFF and cleared by reset.
  - retired_Count increments on each capture edge that loads a valid instruction.
  - squash_Count increments on each valid instruction converted to a bubble by SHADOW or DUMP.
  - stall_Count increments on each edge where STALL=1 and DUMP=0.
- Undefined: the same ports exist but are tied to 0, and no counter logic is generated.

Decomposition:
- Shared package core_pkg holds:
  - state encoding: MOD_RUN=1'b0, MOD_SHADOW=1'b1
  - default SHADOW_DEPTH
  - a packed ex_mem_ctrl_t bundle {valid, mem_wEn, reg_wEn, writeback_Reg}
- One sub-module, branch_shadow_ctrl, owns the RUN/SHADOW state, the counter and redirect_Valid. The top-level module holds the data registers and the optional statistics counters.

Test Plan:
- Reset: hold reset_n=0 with random inputs for 3 cycles, then release -> all outputs 0 and fwd_Valid=0.
- Straight-line: ALU=0x0000_1234, reg_wEn=1, rd=5, valid=1 for one cycle -> next cycle ALU_Result_In=0x1234, fwd_Valid=1, fwd_Reg=5; with rd=0 -> fwd_Valid=0.
- Taken branch: PC=0x0040, target=0x0080, next_PC_select=1, followed by 2 valid instructions (SHADOW_DEPTH=2) -> redirect_Valid high for 1 cycle with redirect_PC=0x0080; next 2 slots have valid_In_Memory=0 and mem_wEn=0; 3rd instruction valid.
- Stall inside shadow: branch, then STALL for 3 cycles, then 2 instructions -> redirect_Valid high 1 cycle only; the 2 instructions are squashed after the stall; stall_Count=3 when EX_MEM_STATS_EN is defined.
- DUMP versus branch: branch captured, DUMP and STALL both high on the next edge -> slot becomes a bubble, state is RUN, and the following valid instruction is captured as valid.
- Nested branch in shadow: a taken branch arrives as the 1st shadow instruction -> no second redirect, and that instruction is squashed.
